pipelined_adder: RTL and testbench

//  Parametrised successor to the single-bit full adder: a WIDTH-bit add/subtract unit split into STAGES

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_stage.sv | 73 +++++++
 rtl/pipelined_adder.sv | 119 +++++++++++
 tb/tb_pipelined_adder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit:
// operation encodings and saturation constants.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned MAX_W = 64;

    // Largest signed value representable in w bits (0111...1)
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest signed value representable in w bits (1000...0)
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-pipelined slice: adds chunk IDX of the operands
// and holds the running result in a valid/ready register.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic             up_op,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_cy,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic             dn_op,
    output logic [WIDTH-1:0] dn_sum,
    output logic             dn_cy,
    output logic             load,
    output logic [WIDTH-1:0] nxt_sum,
    output logic             nxt_cy
);

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   part;

    assign up_ready = !dn_valid || dn_ready;
    assign load     = up_valid && up_ready;

    // Add this stage's chunk, inverting b for subtraction
    always_comb begin
        a_c = up_a[IDX*CHUNK +: CHUNK];
        b_c = up_b[IDX*CHUNK +: CHUNK];
        if (up_op == OP_SUB) begin
            b_c = ~b_c;
        end
        part = {1'b0, a_c} + {1'b0, b_c}
             + {{CHUNK{1'b0}}, up_cy};
        nxt_sum = up_sum;
        nxt_sum[IDX*CHUNK +: CHUNK] = part[CHUNK-1:0];
        nxt_cy = part[CHUNK];
    end

    // Slice register: advance when downstream frees up, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_a     <= '0;
            dn_b     <= '0;
            dn_op    <= 1'b0;
            dn_sum   <= '0;
            dn_cy    <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_a   <= up_a;
                dn_b   <= up_b;
                dn_op  <= up_op;
                dn_sum <= nxt_sum;
                dn_cy  <= nxt_cy;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit split into STAGES carry-pipelined slices.
// Define ADDER_SAT_EN to clamp overflowing results to signed max/min.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             vld   [STAGES+1];
    logic             rdy   [STAGES+1];
    logic [WIDTH-1:0] a_p   [STAGES+1];
    logic [WIDTH-1:0] b_p   [STAGES+1];
    logic             op_p  [STAGES+1];
    logic [WIDTH-1:0] s_p   [STAGES+1];
    logic             cy_p  [STAGES+1];
    logic             ld    [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];

    assign vld[0]      = in_valid;
    assign a_p[0]      = a;
    assign b_p[0]      = b;
    assign op_p[0]     = op;
    assign s_p[0]      = '0;
    assign cy_p[0]     = c_in;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];
    assign out_valid   = vld[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (i)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .up_a     (a_p[i]),
            .up_b     (b_p[i]),
            .up_op    (op_p[i]),
            .up_sum   (s_p[i]),
            .up_cy    (cy_p[i]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1]),
            .dn_a     (a_p[i+1]),
            .dn_b     (b_p[i+1]),
            .dn_op    (op_p[i+1]),
            .dn_sum   (s_p[i+1]),
            .dn_cy    (cy_p[i+1]),
            .load     (ld[i]),
            .nxt_sum  (nxt_s[i]),
            .nxt_cy   (nxt_c[i])
        );
    end

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             a_msb;
    logic             be_msb;
    logic             ovf_n;
    logic             zero_n;

    // Flags from the last slice's fully assembled result
    always_comb begin
        raw    = nxt_s[LAST];
        a_msb  = a_p[LAST][WIDTH-1];
        be_msb = b_p[LAST][WIDTH-1] ^ (op_p[LAST] == OP_SUB);
        ovf_n  = (a_msb == be_msb) && (raw[WIDTH-1] != a_msb);
        res    = raw;
`ifdef ADDER_SAT_EN
        if (ovf_n) begin
            res = a_msb ? SAT_MIN : SAT_MAX;
        end
`endif
        zero_n = (res == '0);
    end

    // Output register loads together with the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (ld[LAST]) begin
            sum   <= res;
            c_out <= nxt_c[LAST];
            ovf   <= ovf_n;
            zero  <= zero_n;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=8, STAGES=2).
// Expectations follow ADDER_SAT_EN when it is defined.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
    logic       zero;

    int n_chk  = 0;
    int n_fail = 0;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Issue one op into an empty pipe; wait (bounded) for out_valid
    task automatic run_op(input logic [7:0] pa, input logic [7:0] pb,
                          input logic pc, input logic po,
                          output int lat);
        @(negedge clk);
        a = pa; b = pb; c_in = pc; op = po; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset;
        logic [11:0] got;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; op = 1'b0;
        #12;
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 000", got);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        logic [11:0] got;
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d want 2", lat);
        end
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'h810) begin
            n_fail++;
            $display("FAIL add_0f_01: got %h want 810", got);
        end
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'hD00) begin
            n_fail++;
            $display("FAIL add_ff_01: got %h want D00", got);
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [11:0] got;
        logic [11:0] exp;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        got = {out_valid, c_out, ovf, zero, sum};
`ifdef ADDER_SAT_EN
        exp = 12'hA7F;
`else
        exp = 12'hA80;
`endif
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_7f_01: got %h want %h", got, exp);
        end
        run_op(8'h80, 8'hFF, 1'b0, 1'b0, lat);
        got = {out_valid, c_out, ovf, zero, sum};
`ifdef ADDER_SAT_EN
        exp = 12'hE80;
`else
        exp = 12'hE7F;
`endif
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ovf_80_ff: got %h want %h", got, exp);
        end
    endtask

    task automatic test_sub;
        int lat;
        logic [11:0] got;
        run_op(8'h05, 8'h07, 1'b1, 1'b1, lat);
        n_chk++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL sub_latency: got %0d want 2", lat);
        end
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'h8FE) begin
            n_fail++;
            $display("FAIL sub_05_07: got %h want 8FE", got);
        end
        run_op(8'h07, 8'h05, 1'b1, 1'b1, lat);
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'hC02) begin
            n_fail++;
            $display("FAIL sub_07_05: got %h want C02", got);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vc [4];
        logic       vo [4];
        logic [8:0] ve [4];
        logic [8:0] held;
        logic       stalled;
        logic       acc;
        logic       drn;
        int         sent;
        int         got;
        va = '{8'h01, 8'h10, 8'hF0, 8'h30};
        vb = '{8'h02, 8'h20, 8'h20, 8'h10};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1};
        vo = '{1'b0, 1'b0, 1'b0, 1'b1};
        ve = '{9'h003, 9'h030, 9'h110, 9'h120};
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                a = va[sent]; b = vb[sent];
                c_in = vc[sent]; op = vo[sent];
            end
            #1;
            if (stalled) begin
                n_chk++;
                if (out_valid !== 1'b1 || {c_out, sum} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                             out_valid, {c_out, sum}, held);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_in_ready cyc%0d: got %b want 0",
                             cyc, in_ready);
                end
            end
            acc     = in_valid && in_ready;
            drn     = out_valid && out_ready;
            stalled = out_valid && !out_ready;
            held    = {c_out, sum};
            if (drn) begin
                n_chk++;
                if (got >= 4) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got result %h want none", held);
                end else if (held !== ve[got]) begin
                    n_fail++;
                    $display("FAIL b2b_order%0d: got %h want %h",
                             got, held, ve[got]);
                end
                got++;
            end
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 4", got);
        end
    endtask

    task automatic test_reset_midflight;
        int lat;
        int stale;
        logic [11:0] got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h01; c_in = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 8'h7F; b = 8'h01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'hD00) begin
            n_fail++;
            $display("FAIL pre_reset_result: got %h want D00", got);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h want 000", got);
        end
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_chk++;
        if (stale !== 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d valid cycles want 0",
                     stale);
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        n_chk++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d want 2", lat);
        end
        got = {out_valid, c_out, ovf, zero, sum};
        n_chk++;
        if (got !== 12'h846) begin
            n_fail++;
            $display("FAIL post_reset_12_34: got %h want 846", got);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
